// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin2bcd_seq #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  // Wide enough to hold both the input and the largest representable decimal value
  localparam int XW = (IN_WIDTH > 64) ? IN_WIDTH : 64;

  function automatic logic [XW-1:0] max_decimal(input int n);
    logic [XW-1:0] p;
    p = XW'(1);
    for (int i = 0; i < n; i++) begin
      p = p * XW'(10);
    end
    return p - XW'(1);
  endfunction

  localparam logic [XW-1:0] MAX_DEC = max_decimal(DIGITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] bin_r;
  logic [IN_WIDTH-1:0] bin_nxt;
  logic [BW-1:0]       bcd_r;
  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_nxt;
  logic [CW-1:0]       cnt;
  logic                ovf_r;
  logic                in_ovf;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end
    end
    {bcd_nxt, bin_nxt} = {bcd_adj[BW-2:0], bin_r, 1'b0};
  end

  // Range check on the raw input, latched when a conversion is accepted
  always_comb begin
    in_ovf = XW'(bin_in) > MAX_DEC;
  end

  // Control FSM plus working and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin_r    <= '0;
      bcd_r    <= '0;
      cnt      <= '0;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_r <= bin_in;
            bcd_r <= '0;
            cnt   <= '0;
            ovf_r <= in_ovf;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bin_r <= bin_nxt;
          bcd_r <= bcd_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(IN_WIDTH - 1)) begin
            bcd_out  <= ovf_r ? {DIGITS{4'h9}} : bcd_nxt;
            overflow <= ovf_r;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

  localparam int LAT = 32;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic [31:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic        overflow;

  bin2bcd_seq #(.IN_WIDTH(32), .DIGITS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e;
    logic [31:0] bcd;
    logic        ovf;
  } item_t;

  item_t       q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_bcd    = '0;
  logic        last_ovf    = 1'b0;

  // Reference: decimal digits by repeated division, saturate above 8 digits
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    longint unsigned n;
    logic [31:0]     r;
    n = longint'(v);
    r = '0;
    if (n > 64'd99999999) return 32'h99999999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] v);
    return v > 32'd99999999;
  endfunction

  function automatic bit model_idle();
    return (q.size() == 0) || (cyc >= q[q.size()-1].e + LAT);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every cycle against the scoreboard head
  item_t mon_it;
  logic  exp_done;
  logic  exp_busy;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      exp_done = (q.size() > 0) && (cyc == q[0].e + LAT);
      exp_busy = (q.size() > 0) && (cyc >= q[0].e) && (cyc < q[0].e + LAT);
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        mon_it = q.pop_front();
        check("bcd_out", bcd_out, mon_it.bcd);
        check("overflow", {31'b0, overflow}, {31'b0, mon_it.ovf});
        last_bcd = mon_it.bcd;
        last_ovf = mon_it.ovf;
      end else begin
        check("bcd_hold", bcd_out, last_bcd);
        check("ovf_hold", {31'b0, overflow}, {31'b0, last_ovf});
      end
    end
  end

  // Drive start for one edge; record expectation only if the model says idle
  task automatic issue(input logic [31:0] v);
    item_t it;
    start  = 1'b1;
    bin_in = v;
    if (model_idle()) begin
      it.e   = cyc + 1;
      it.bcd = ref_bcd(v);
      it.ovf = ref_ovf(v);
      q.push_back(it);
    end
    @(negedge clk);
    start  = 1'b0;
    bin_in = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_bcd"}, bcd_out, 32'd0);
    check({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] v;
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_cleared("reset");

    issue(32'd0);
    wait_idle();
    issue(32'h00BC614E);
    wait_idle();
    issue(32'd99999999);
    wait_idle();
    issue(32'd100000000);
    wait_idle();
    issue(32'hFFFFFFFF);
    wait_idle();

    // Second start during a conversion is ignored
    issue(32'd5);
    repeat (9) @(negedge clk);
    issue(32'd7);
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset mid-conversion aborts with no done
    issue(32'd4321);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    q.delete();
    last_bcd = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("abort");
    repeat (40) @(negedge clk);
    issue(32'd4321);
    wait_idle();

    // Start in the done cycle is accepted
    issue(32'd77);
    repeat (LAT) @(negedge clk);
    check("done_b2b", {31'b0, done}, 32'd1);
    issue(32'd9);
    wait_idle();

    // Randomized traffic with inputs toggling during conversions
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: v = $urandom_range(99);
          1: v = $urandom_range(100000100, 99999900);
          2: v = $urandom;
          default: v = $urandom_range(99999999);
        endcase
        issue(v);
      end else begin
        bin_in = $urandom;
        @(negedge clk);
      end
    end
    wait_idle();
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
